trace_event_sequencer: RTL and testbench
========================================

// Module: trace_event_sequencer
// PURPOSE
// Drains the trace sniff FIFO in hardware on trace_clk. It rebuilds each match
// event's absolute timestamp from TIME and MATCH entries and presents
// {rule, time} records on a valid/ready port to the register/USB side.
// It stops after a programmed number of events, reports completion, and keeps
// sticky error flags.
// PARAMETERS
// pTIME_W      32  width of reconstructed timestamp accumulator / evt_time
// pCOUNT_W     16  width of cfg_num_events and evt_count
// PORTS
// trace_clk       in   1         sole clock
// reset           in   1         synchronous, active-high
// enable          in   1         level; 1=run sequencer, 0=return to IDLE
// cfg_num_events  in   pCOUNT_W  events to emit before DONE; 0=unlimited
// fifo_empty      in   1         sniff FIFO empty (first-word-fall-through)
// fifo_dout       in   18        head entry, valid when !fifo_empty
// fifo_rd         out  1         pop strobe, one entry per asserted cycle
// evt_valid       out  1         event record valid
// evt_ready       in   1         consumer accepts when evt_valid&&evt_ready
// evt_rule        out  8         match rule index
// evt_time        out  pTIME_W   absolute timestamp of the event
// evt_count       out  pCOUNT_W  events accepted by consumer since run start
// last_stat       out  6         payload of most recent STAT entry
// done            out  1         high in DONE state
// err_reserved    out  1         sticky: reserved cmd (2'b11) popped
// BEHAVIOUR
// - Entry format: cmd=fifo_dout[1:0]: 00 MATCH, 01 TIME, 10 STAT, 11 reserved.
//   MATCH: short time=[7:2] (6b), rule=[15:8]. TIME: full time=[17:2] (16b).
//   STAT: stat=[7:2].
// - Reset: state=IDLE. fifo_rd=0, evt_valid=0, evt_rule=0, evt_time=0.
//   evt_count=0, last_stat=0, done=0, err_reserved=0, acc=0.
// - States: IDLE -> RUN when enable=1 (clears acc, evt_count, err_reserved);
//   RUN -> DONE when an accepted event makes evt_count==cfg_num_events (nonzero);
//   RUN/DONE -> IDLE when enable=0 (any pending evt_valid is dropped).
//   DONE: no pops; evt_valid may still drain.
// - fifo_rd is combinational: state==RUN && !fifo_empty && (cmd!=MATCH ||
//   !evt_valid || evt_ready). A MATCH is never popped while the output slot is
//   full and not draining. Non-MATCH entries pop regardless of backpressure.
// - Entry decode happens in the pop cycle; effects register on the same edge:
//   TIME: acc <= zero-ext full time. Overwrites, so consecutive TIMEs keep the
//   last one.
//   MATCH: evt_time <= acc + short (mod 2^pTIME_W), evt_rule <= rule,
//   evt_valid <= 1, acc <= 0.
//   STAT: last_stat <= stat; acc unchanged.
//   reserved: discarded, err_reserved <= 1, acc unchanged.
// - Latency: MATCH pop at edge N -> evt_valid high after edge N. Throughput is
//   one event per cycle while evt_ready=1.
// - evt_valid falls on an accept edge unless a new MATCH loads on that same
//   edge. evt_rule/evt_time stay stable while evt_valid && !evt_ready.
// - evt_count increments on each accept and saturates at all-ones. With
//   cfg_num_events=0, DONE is never reached.
// - cfg_num_events is sampled on IDLE->RUN. Later changes are ignored until the
//   next run.
// - reset mid-run: immediate return to reset values on the next edge; the FIFO
//   entry under decode is not popped.
// TESTING
// T1 TIME(0x0120), MATCH(rule 3, short 5), ready=1 -> evt_rule=3,
//    evt_time=0x125, fifo_rd exactly 2 cycles.
// T2 MATCH(r1,s7), MATCH(r2,s2) with no TIME -> times 7 then 2 (acc cleared
//    after each match).
// T3 TIME(0x10), TIME(0x40), STAT(0x2A), MATCH(r0,s1) -> evt_time=0x41,
//    last_stat=0x2A.
// T4 evt_ready held 0 for 10 cycles with 2 MATCHes queued -> exactly 1 pop; first
//    record stable; second pops on the accept cycle (back-to-back).
// T5 cfg_num_events=2, 4 MATCHes queued -> 2 accepted, done=1, 2 entries remain;
//    enable=0 -> IDLE, done=0.
// T6 reserved entry, then reset asserted mid-RUN with fifo nonempty ->
//    err_reserved=1 before reset; all outputs 0 and fifo_rd=0 after reset.

Source files
------------

// File: rtl/trace_event_sequencer.sv
// Purpose : drains the trace sniff FIFO, rebuilds absolute match timestamps and emits {rule, time} records.
// Latency : a MATCH popped at edge N shows up on evt_valid/evt_rule/evt_time right after edge N.
// Backpr. : a MATCH is only popped when the output slot is empty or draining; TIME/STAT/reserved always pop.
//
// Ports:
//   trace_clk, reset          sole clock, synchronous active-high reset
//   enable                    level; 1 = run, 0 = return to IDLE (pending record dropped)
//   cfg_num_events            events to emit before DONE (0 = unlimited), sampled on IDLE->RUN
//   fifo_empty/fifo_dout      first-word-fall-through head of the sniff FIFO
//   fifo_rd                   combinational pop strobe
//   evt_valid/evt_ready       record handshake; evt_rule/evt_time are the record payload
//   evt_count                 records accepted this run (saturating)
//   last_stat                 payload of the most recent STAT entry
//   done                      high in DONE state
//   err_reserved              sticky, set when a reserved entry is popped
module trace_event_sequencer #(
    parameter int pTIME_W  = 32,
    parameter int pCOUNT_W = 16
) (
    input  logic                trace_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [pCOUNT_W-1:0] cfg_num_events,
    input  logic                fifo_empty,
    input  logic [17:0]         fifo_dout,
    output logic                fifo_rd,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [7:0]          evt_rule,
    output logic [pTIME_W-1:0]  evt_time,
    output logic [pCOUNT_W-1:0] evt_count,
    output logic [5:0]          last_stat,
    output logic                done,
    output logic                err_reserved
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CMD_MATCH = 2'b00;
    localparam logic [1:0] CMD_TIME  = 2'b01;
    localparam logic [1:0] CMD_STAT  = 2'b10;

    state_t                state_q, state_d;
    logic [pTIME_W-1:0]    acc_q, acc_d;
    logic                  evt_valid_q, evt_valid_d;
    logic [7:0]            evt_rule_q, evt_rule_d;
    logic [pTIME_W-1:0]    evt_time_q, evt_time_d;
    logic [pCOUNT_W-1:0]   evt_count_q, evt_count_d;
    logic [pCOUNT_W-1:0]   cfg_num_q, cfg_num_d;
    logic [5:0]            last_stat_q, last_stat_d;
    logic                  err_reserved_q, err_reserved_d;

    logic [1:0]            head_cmd;
    logic                  accept;
    logic [pCOUNT_W-1:0]   count_inc;
    logic                  hit_target;
    logic                  pop;

    always_comb begin
        head_cmd  = fifo_dout[1:0];
        accept    = evt_valid_q && evt_ready;
        count_inc = (&evt_count_q) ? evt_count_q : evt_count_q + pCOUNT_W'(1);
        // The accept that completes the programmed count ends the run; nothing
        // else is consumed on that edge so the remaining entries stay queued.
        hit_target = (state_q == ST_RUN) && accept && (cfg_num_q != '0)
                     && (count_inc == cfg_num_q);
        // Gated by reset and enable so an entry is never popped on an edge
        // where its decode would be thrown away.
        pop = !reset && enable && (state_q == ST_RUN) && !fifo_empty && !hit_target
              && ((head_cmd != CMD_MATCH) || !evt_valid_q || evt_ready);
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        evt_valid_d    = evt_valid_q;
        evt_rule_d     = evt_rule_q;
        evt_time_d     = evt_time_q;
        evt_count_d    = evt_count_q;
        cfg_num_d      = cfg_num_q;
        last_stat_d    = last_stat_q;
        err_reserved_d = err_reserved_q;

        if (accept) begin
            evt_valid_d = 1'b0;
            evt_count_d = count_inc;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d        = ST_RUN;
                    acc_d          = '0;
                    evt_count_d    = '0;
                    err_reserved_d = 1'b0;
                    cfg_num_d      = cfg_num_events;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d     = ST_IDLE;
                    evt_valid_d = 1'b0;
                end else if (hit_target) begin
                    state_d = ST_DONE;
                end
                if (pop) begin
                    case (head_cmd)
                        CMD_MATCH: begin
                            // A new MATCH loading on an accept edge keeps valid high.
                            evt_time_d  = acc_q + pTIME_W'(fifo_dout[7:2]);
                            evt_rule_d  = fifo_dout[15:8];
                            evt_valid_d = 1'b1;
                            acc_d       = '0;
                        end
                        CMD_TIME: begin
                            acc_d = pTIME_W'(fifo_dout[17:2]);
                        end
                        CMD_STAT: begin
                            last_stat_d = fifo_dout[7:2];
                        end
                        default: begin
                            err_reserved_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_d     = ST_IDLE;
                    evt_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            acc_q          <= '0;
            evt_valid_q    <= 1'b0;
            evt_rule_q     <= '0;
            evt_time_q     <= '0;
            evt_count_q    <= '0;
            cfg_num_q      <= '0;
            last_stat_q    <= '0;
            err_reserved_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            evt_valid_q    <= evt_valid_d;
            evt_rule_q     <= evt_rule_d;
            evt_time_q     <= evt_time_d;
            evt_count_q    <= evt_count_d;
            cfg_num_q      <= cfg_num_d;
            last_stat_q    <= last_stat_d;
            err_reserved_q <= err_reserved_d;
        end
    end

    assign fifo_rd      = pop;
    assign evt_valid    = evt_valid_q;
    assign evt_rule     = evt_rule_q;
    assign evt_time     = evt_time_q;
    assign evt_count    = evt_count_q;
    assign last_stat    = last_stat_q;
    assign done         = (state_q == ST_DONE);
    assign err_reserved = err_reserved_q;

endmodule

// File: tb/tb_trace_event_sequencer.sv
// Directed bench for trace_event_sequencer: a table of single-event vectors
// plus hand-written sequences for backpressure, event limit and reset.
module tb_trace_event_sequencer;

    logic        trace_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] cfg_num_events;
    logic        fifo_empty;
    logic [17:0] fifo_dout;
    logic        fifo_rd;
    logic        evt_valid;
    logic        evt_ready;
    logic [7:0]  evt_rule;
    logic [31:0] evt_time;
    logic [15:0] evt_count;
    logic [5:0]  last_stat;
    logic        done;
    logic        err_reserved;

    always #5 trace_clk = ~trace_clk;

    trace_event_sequencer #(.pTIME_W(32), .pCOUNT_W(16)) dut (
        .trace_clk      (trace_clk),
        .reset          (reset),
        .enable         (enable),
        .cfg_num_events (cfg_num_events),
        .fifo_empty     (fifo_empty),
        .fifo_dout      (fifo_dout),
        .fifo_rd        (fifo_rd),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_rule       (evt_rule),
        .evt_time       (evt_time),
        .evt_count      (evt_count),
        .last_stat      (last_stat),
        .done           (done),
        .err_reserved   (err_reserved)
    );

    // FWFT FIFO model: mem/wr_ptr owned by the stimulus, rd_ptr by the pop process.
    logic [17:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        rd_seen;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = fifo_empty ? 18'h0 : mem[rd_ptr & 63];

    always @(posedge trace_clk) begin
        rd_seen = fifo_rd;
        #1;
        if (rd_seen && (rd_ptr != wr_ptr)) rd_ptr = rd_ptr + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [17:0] e);
        mem[wr_ptr & 63] = e;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [17:0] e_match(input logic [7:0] r, input logic [5:0] s);
        return {2'b00, r, s, 2'b00};
    endfunction
    function automatic logic [17:0] e_time(input logic [15:0] t);
        return {t, 2'b01};
    endfunction
    function automatic logic [17:0] e_stat(input logic [5:0] s);
        return {10'h000, s, 2'b10};
    endfunction

    task automatic wait_valid(input int max_cyc, input string tag);
        int n;
        n = 0;
        @(negedge trace_clk);
        while (evt_valid !== 1'b1 && n < max_cyc) begin
            @(negedge trace_clk);
            n++;
        end
        if (evt_valid !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: evt_valid never rose within %0d cycles", tag, max_cyc);
        end
    endtask

    typedef struct {
        logic        use_time;
        logic [15:0] tval;
        logic [7:0]  rule;
        logic [5:0]  sh;
        logic [31:0] exp_time;
        logic [7:0]  exp_rule;
        int          exp_pops;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int p0;
        int n;

        vecs[0] = '{1'b1, 16'h0120, 8'd3,   6'd5,  32'h0000_0125, 8'd3,   2};
        vecs[1] = '{1'b0, 16'h0000, 8'd1,   6'd7,  32'h0000_0007, 8'd1,   1};
        vecs[2] = '{1'b0, 16'h0000, 8'd2,   6'd2,  32'h0000_0002, 8'd2,   1};
        vecs[3] = '{1'b1, 16'hFFFF, 8'hFF,  6'h3F, 32'h0001_003E, 8'hFF,  2};
        vecs[4] = '{1'b1, 16'h0000, 8'h80,  6'h00, 32'h0000_0000, 8'h80,  2};

        reset          = 1'b1;
        enable         = 1'b0;
        cfg_num_events = 16'd0;
        evt_ready      = 1'b0;
        repeat (3) @(negedge trace_clk);
        chk("rst_valid",   {31'b0, evt_valid}, 0);
        chk("rst_rule",    {24'b0, evt_rule}, 0);
        chk("rst_time",    evt_time, 0);
        chk("rst_count",   {16'b0, evt_count}, 0);
        chk("rst_stat",    {26'b0, last_stat}, 0);
        chk("rst_done",    {31'b0, done}, 0);
        chk("rst_err",     {31'b0, err_reserved}, 0);
        chk("rst_fifo_rd", {31'b0, fifo_rd}, 0);

        reset     = 1'b0;
        enable    = 1'b1;
        evt_ready = 1'b1;
        @(negedge trace_clk);

        // Single-event vectors with consumer always ready.
        for (int i = 0; i < 5; i++) begin
            p0 = rd_ptr;
            if (vecs[i].use_time) push(e_time(vecs[i].tval));
            push(e_match(vecs[i].rule, vecs[i].sh));
            wait_valid(20, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_rule", i), {24'b0, evt_rule}, {24'b0, vecs[i].exp_rule});
            chk($sformatf("vec%0d_time", i), evt_time, vecs[i].exp_time);
            chk($sformatf("vec%0d_pops", i), rd_ptr - p0, vecs[i].exp_pops);
            @(negedge trace_clk);
        end
        chk("tbl_count", {16'b0, evt_count}, 5);

        // TIME overwrite, STAT capture.
        push(e_time(16'h0010));
        push(e_time(16'h0040));
        push(e_stat(6'h2A));
        push(e_match(8'd0, 6'd1));
        wait_valid(20, "t3");
        chk("t3_time", evt_time, 32'h41);
        chk("t3_rule", {24'b0, evt_rule}, 0);
        chk("t3_stat", {26'b0, last_stat}, 32'h2A);
        @(negedge trace_clk);

        // Backpressure: two MATCHes queued, consumer stalls 10 cycles.
        evt_ready = 1'b0;
        p0 = rd_ptr;
        push(e_match(8'd5, 6'd3));
        push(e_match(8'd6, 6'd4));
        repeat (10) @(negedge trace_clk);
        chk("t4_pops_stall", rd_ptr - p0, 1);
        chk("t4_valid_stall", {31'b0, evt_valid}, 1);
        chk("t4_rule_stall", {24'b0, evt_rule}, 5);
        chk("t4_time_stall", evt_time, 3);
        evt_ready = 1'b1;
        #1;
        chk("t4_rd_on_accept", {31'b0, fifo_rd}, 1);
        @(negedge trace_clk);
        chk("t4_valid_b2b", {31'b0, evt_valid}, 1);
        chk("t4_rule_b2b", {24'b0, evt_rule}, 6);
        chk("t4_time_b2b", evt_time, 4);
        chk("t4_pops_b2b", rd_ptr - p0, 2);
        @(negedge trace_clk);
        chk("t4_valid_end", {31'b0, evt_valid}, 0);
        chk("t4_count", {16'b0, evt_count}, 8);

        // Event limit of 2 with 4 MATCHes queued.
        enable = 1'b0;
        @(negedge trace_clk);
        cfg_num_events = 16'd2;
        push(e_match(8'd11, 6'd1));
        push(e_match(8'd12, 6'd2));
        push(e_match(8'd13, 6'd3));
        push(e_match(8'd14, 6'd4));
        enable = 1'b1;
        n = 0;
        @(negedge trace_clk);
        while (done !== 1'b1 && n < 20) begin
            @(negedge trace_clk);
            n++;
        end
        cfg_num_events = 16'd1;
        chk("t5_done", {31'b0, done}, 1);
        chk("t5_count", {16'b0, evt_count}, 2);
        chk("t5_left", wr_ptr - rd_ptr, 2);
        chk("t5_valid", {31'b0, evt_valid}, 0);
        repeat (3) @(negedge trace_clk);
        chk("t5_left_hold", wr_ptr - rd_ptr, 2);
        chk("t5_done_hold", {31'b0, done}, 1);
        enable = 1'b0;
        @(negedge trace_clk);
        chk("t5_done_idle", {31'b0, done}, 0);
        chk("t5_rd_idle", {31'b0, fifo_rd}, 0);

        // Drain leftovers, then reserved entry and reset mid-run.
        cfg_num_events = 16'd0;
        enable = 1'b1;
        repeat (6) @(negedge trace_clk);
        chk("t6_drained", wr_ptr - rd_ptr, 0);
        chk("t6_count_new_run", {16'b0, evt_count}, 2);
        evt_ready = 1'b0;
        push(18'h00003);
        push(e_match(8'd9, 6'd9));
        push(e_match(8'd10, 6'd1));
        repeat (6) @(negedge trace_clk);
        chk("t6_err", {31'b0, err_reserved}, 1);
        chk("t6_valid", {31'b0, evt_valid}, 1);
        chk("t6_rule", {24'b0, evt_rule}, 9);
        chk("t6_time", evt_time, 9);
        chk("t6_left", wr_ptr - rd_ptr, 1);
        reset = 1'b1;
        #1;
        chk("t6_rd_in_reset", {31'b0, fifo_rd}, 0);
        @(negedge trace_clk);
        chk("t6_valid_rst", {31'b0, evt_valid}, 0);
        chk("t6_rule_rst", {24'b0, evt_rule}, 0);
        chk("t6_time_rst", evt_time, 0);
        chk("t6_count_rst", {16'b0, evt_count}, 0);
        chk("t6_stat_rst", {26'b0, last_stat}, 0);
        chk("t6_done_rst", {31'b0, done}, 0);
        chk("t6_err_rst", {31'b0, err_reserved}, 0);
        chk("t6_left_rst", wr_ptr - rd_ptr, 1);
        reset = 1'b0;
        enable = 1'b0;
        @(negedge trace_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
